// File: rtl/decode_fetch_buffer.sv
// IF->ID instruction buffer: a DEPTH-entry show-ahead FIFO of {pc, instr}
// pairs. It also handles branch-flush recovery, presents a NOP when empty
// and keeps a saturating count of squashed entries.
module decode_fetch_buffer #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int              CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       squash_cnt
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL  = OCC_W'(DEPTH);

  // Add the squashed occupancy to the perf counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [OCC_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             push, pop;

  // Handshake flags depend only on occupancy; in_ready never looks at out_ready.
  assign in_ready   = (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign count      = count_q;
  assign squash_cnt = squash_cnt_q;

  // Head entry is presented directly; when empty, storage is never read so
  // uninitialised entries cannot leak onto the outputs.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (out_valid) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and squash counter; flush outranks push/pop.
  always_comb begin
    push         = in_valid && in_ready && !flush;
    pop          = out_valid && out_ready && !flush;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    squash_cnt_d = squash_cnt_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      squash_cnt_d = sat_add(squash_cnt_q, count_q);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      squash_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // Entry storage; written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_decode_fetch_buffer.sv
// Bench for decode_fetch_buffer: a queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, then
// randomized traffic.
module tb_decode_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SQ_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic [CNT_W-1:0] squash_cnt;

  decode_fetch_buffer #(
    .XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .count(count), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   sq = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO queue advanced once per rising edge.
  task automatic model_step();
    bit   do_push, do_pop;
    ent_t e;
    if (rst) begin
      q.delete();
      sq = 0;
    end else if (flush) begin
      sq = sq + q.size();
      if (sq > SQ_MAX) sq = SQ_MAX;
      q.delete();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = in_pc;
        e.instr = in_instr;
        q.push_back(e);
      end
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("out_pc", 64'(out_pc), (q.size() > 0) ? 64'(q[0].pc) : 64'h0);
      chk("out_instr", 64'(out_instr), (q.size() > 0) ? 64'(q[0].instr) : 64'h13);
      chk("squash_cnt", 64'(squash_cnt), 64'(sq));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = $urandom;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;

    // Reset
    @(negedge clk); #1;
    do_reset();
    chk_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'h13);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    chk("rst_squash", 64'(squash_cnt), 64'd0);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h60 + 32'(4 * i), 0, 0);
      cyc();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_head_pc", 64'(out_pc), 64'h60);
    chk("fill_model_size", 64'(q.size()), 64'd4);
    drive(1, 32'h70, 0, 0);
    cyc();
    chk("full_drop_head", 64'(out_pc), 64'h60);
    chk("full_drop_count", 64'(count), 64'd4);

    // Drain to two, then stream at steady occupancy
    drive(0, 0, 1, 0); cyc(); cyc();
    chk("drain_head_pc", 64'(out_pc), 64'h68);
    pc = 32'h100;
    for (int i = 0; i < 10; i++) begin
      drive(1, pc, 1, 0);
      cyc();
      pc += 4;
      chk("stream_count", 64'(count), 64'd2);
    end
    chk("stream_head_pc", 64'(out_pc), 64'h120);

    // Empty latency: one push into an empty buffer is visible next cycle
    drive(0, 0, 1, 0); cyc(); cyc();
    chk("empty_out_valid", 64'(out_valid), 64'd0);
    drive(1, 32'h200, 1, 0); cyc();
    chk("latency_head_pc", 64'(out_pc), 64'h200);
    drive(0, 0, 1, 0); cyc();

    // Flush with three entries and a concurrent beat
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 0, 0);
      cyc();
    end
    drive(1, 32'h3F0, 1, 1); cyc();
    drive(0, 0, 0, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_instr", 64'(out_instr), 64'h13);
    chk("flush_squash", 64'(squash_cnt), 64'd3);
    cyc();
    chk("flush_beat_dropped", 64'(out_valid), 64'd0);

    // Saturation: 3 + 4*4 = 19 squashed entries clamps at 15
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, 32'h400 + 32'(4 * i), 0, 0);
        cyc();
      end
      drive(0, 0, 0, 1); cyc();
    end
    drive(0, 0, 0, 0);
    chk("sat_squash", 64'(squash_cnt), 64'd15);
    chk("sat_model", 64'(sq), 64'd15);

    // Reset mid-stream with two entries
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 0, 0);
      cyc();
    end
    drive(1, 32'h508, 1, 0);
    rst = 1'b1; cyc(); rst = 1'b0;
    drive(0, 0, 0, 0);
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_squash", 64'(squash_cnt), 64'd0);

    // Randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
      pc += 4;
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
    cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
